// File: rtl/multiplier_main_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_main_pkg
// Shared definitions for the shift-add multiplier (and its divider sibling):
// operand width, FSM state width and encoding, iteration counter width, and a
// helper that zero-extends an operand to the double-width datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package multiplier_main_pkg;

    localparam int WIDTH       = 32;
    localparam int STATE_WIDTH = 2;
    localparam int COUNT_WIDTH = $clog2(WIDTH) + 1;

    // Count value seen during the final shift-add iteration.
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WIDTH - 1);

    typedef enum logic [STATE_WIDTH-1:0] {
        INIT = STATE_WIDTH'(0),
        S1   = STATE_WIDTH'(1),
        STOP = STATE_WIDTH'(2)
    } state_t;

    function automatic logic [2*WIDTH-1:0] widen(input logic [WIDTH-1:0] value);
        return {{WIDTH{1'b0}}, value};
    endfunction

endpackage

// File: rtl/multiplier_main.sv
// -----------------------------------------------------------------------------
// multiplier_main
// Sequential shift-add multiplier computing A = Q*B + R in exactly WIDTH
// iterations. It rebuilds a dividend from the restoring divider's quotient,
// divisor and remainder, and doubles as a general multiply-accumulate unit.
//
// Ports:
//   Clk    in   1        rising-edge clock
//   Rst    in   1        asynchronous active-low reset
//   start  in   1        level request, only looked at in INIT
//   Q      in   WIDTH    multiplier (quotient)
//   B      in   WIDTH    multiplicand (divisor)
//   R      in   WIDTH    addend (remainder), preloaded into the accumulator
//   A      out  2*WIDTH  registered result Q*B + R
//   done   out  1        high while parked in STOP with a valid result
//   busy   out  1        high for the WIDTH iteration cycles
// -----------------------------------------------------------------------------
module multiplier_main
    import multiplier_main_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Q,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     R,
    output logic [2*WIDTH-1:0]   A,
    output logic                 done,
    output logic                 busy
);

    state_t                 state;
    logic [2*WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]       mplier;
    logic [2*WIDTH-1:0]     acc;
    logic [COUNT_WIDTH-1:0] count;
    logic [2*WIDTH-1:0]     acc_next;

    // Conditional add of this iteration; also the final result on the last pass.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Single FSM block; done and busy are registered alongside the state so
    // they change on the same edges as the state transitions.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= INIT;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            A      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    done <= 1'b0;
                    if (start) begin
                        // Operands are captured only here; later changes are ignored.
                        mcand  <= widen(B);
                        mplier <= Q;
                        acc    <= widen(R);
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                S1: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        A     <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= STOP;
                    end
                end
                STOP: begin
                    busy <= 1'b0;
                    if (!start) begin
                        done  <= 1'b0;
                        state <= INIT;
                    end else begin
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_main.sv
// Self-checking bench for multiplier_main: directed corner cases, held start,
// mid-operation reset, input freeze, divider round trips and random MACs,
// all checked against plain 64-bit arithmetic.
module tb_multiplier_main;

   logic        Clk;
   logic        Rst;
   logic        start;
   logic [31:0] Q;
   logic [31:0] B;
   logic [31:0] R;
   logic [63:0] A;
   logic        done;
   logic        busy;

   int compareCount;
   int failCount;

   multiplier_main dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .Q     (Q),
      .B     (B),
      .R     (R),
      .A     (A),
      .done  (done),
      .busy  (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
      end
   endtask

   // Reference: the result is simply the exact product plus the addend.
   function automatic logic [63:0] refModel(input logic [31:0] q, input logic [31:0] b, input logic [31:0] r);
      return 64'(q) * 64'(b) + 64'(r);
   endfunction

   // Waits (bounded) for done after the sampling edge; returns cycles taken
   // and how many of the sampled cycles showed busy.
   task automatic waitDone(input bit scramble, output int cycles, output int busyCount);
      cycles = 0;
      busyCount = 0;
      while (!done && cycles < 100) begin
         if (busy) busyCount++;
         if (scramble) begin
            Q = $urandom;
            B = $urandom;
            R = $urandom;
         end
         @(posedge Clk); #1;
         cycles++;
      end
   endtask

   // One full pulsed-start transaction with latency, busy, result and return checks.
   task automatic applyStimulus(input string tag, input logic [31:0] q, input logic [31:0] b,
                                input logic [31:0] r, input bit scramble);
      logic [63:0] expected;
      int cycles;
      int busyCount;
      expected = refModel(q, b, r);
      @(negedge Clk);
      Q = q;
      B = b;
      R = r;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      waitDone(scramble, cycles, busyCount);
      checkOutput({tag, "_latency"}, 64'(cycles), 64'd32);
      checkOutput({tag, "_busy_cycles"}, 64'(busyCount), 64'd32);
      checkOutput({tag, "_result"}, A, expected);
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      @(posedge Clk); #1;
      checkOutput({tag, "_done_fall"}, 64'(done), 64'd0);
      checkOutput({tag, "_result_hold"}, A, expected);
   endtask

   initial begin
      logic [31:0] dividend;
      logic [31:0] divisor;
      logic [63:0] heldExpected;
      int          cycles;
      int          busyCount;

      compareCount = 0;
      failCount    = 0;
      Rst   = 1'b0;
      start = 1'b0;
      Q = '0;
      B = '0;
      R = '0;

      // Reset state
      #1;
      checkOutput("reset_A", A, 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;

      // Directed cases and extremes
      applyStimulus("basic", 32'd4, 32'd3, 32'd1, 1'b0);
      applyStimulus("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      applyStimulus("q_zero", 32'd0, 32'h1234_5678, 32'd7, 1'b0);
      applyStimulus("b_zero", 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
      applyStimulus("freeze", 32'h0001_2345, 32'h0000_ABCD, 32'd99, 1'b1);

      // Held start from reset release: one computation, then parked in STOP
      @(negedge Clk);
      Rst   = 1'b0;
      Q     = 32'd1000;
      B     = 32'd77;
      R     = 32'd5;
      start = 1'b1;
      heldExpected = refModel(32'd1000, 32'd77, 32'd5);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      waitDone(1'b0, cycles, busyCount);
      checkOutput("held_latency", 64'(cycles), 64'd32);
      checkOutput("held_result", A, heldExpected);
      Q = 32'd3;
      for (int i = 0; i < 8; i++) begin
         @(posedge Clk); #1;
         checkOutput("held_done_stays", 64'(done), 64'd1);
         checkOutput("held_busy_low", 64'(busy), 64'd0);
         checkOutput("held_result_stable", A, heldExpected);
      end
      start = 1'b0;
      @(posedge Clk); #1;
      checkOutput("held_release", 64'(done), 64'd0);

      // Reset asserted partway through S1, then a fresh computation
      @(negedge Clk);
      Q = 32'd9;
      B = 32'd9;
      R = 32'd0;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (10) @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      checkOutput("midreset_A", A, 64'd0);
      checkOutput("midreset_done", 64'(done), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      @(negedge Clk);
      Rst = 1'b1;
      applyStimulus("after_reset", 32'd5, 32'd6, 32'd2, 1'b0);

      // Divider round trip: quotient, divisor and remainder rebuild the dividend
      for (int i = 0; i < 100; i++) begin
         dividend = $urandom;
         divisor  = $urandom;
         if (i % 3 == 0) divisor = divisor >> ($urandom_range(31, 0));
         if (divisor == 0) divisor = 32'd1;
         applyStimulus("roundtrip", dividend / divisor, divisor, dividend % divisor, 1'b0);
         checkOutput("roundtrip_dividend", A, 64'(dividend));
      end

      // General multiply-accumulate with unconstrained operands
      for (int i = 0; i < 20; i++) begin
         applyStimulus("mac", $urandom, $urandom, $urandom, (i % 2) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/multiplier_main.md
# multiplier_main

Sequential shift-add multiplier that computes A = Q·B + R, the inverse of the team's restoring divider (`devider_main`). It takes the divider's quotient, divisor and remainder and rebuilds the dividend. Benches use it for round-trip checking of the divider. The datapath also serves as a general multiply-accumulate unit.

## Interface
Parameters (shared defines):
- `WIDTH`, 32: operand width.
- `STATE_WIDTH`, 2: FSM state register width.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled only in INIT.
- `Q`  in  WIDTH  multiplier (quotient).
- `B`  in  WIDTH  multiplicand (divisor).
- `R`  in  WIDTH  addend (remainder).
- `A`  out  2·WIDTH  result Q·B + R, registered.
- `done`  out  1  high while in STOP; the result is valid.
- `busy`  out  1  high while in S1.

## Operation
- Reset (`Rst`=0, asynchronous), applied immediately and independent of `Clk`:
  - state=INIT, `A`=0, `done`=0, `busy`=0.
  - All internal registers are cleared.
- FSM states: INIT, S1, STOP.
- INIT with `start`=1 at a rising edge:
  - Load mcand={WIDTH'b0,B}, mplier=Q, acc={WIDTH'b0,R}, count=0.
  - Go to S1.
- INIT with `start`=0: stay in INIT.
- S1, one iteration per edge:
  - If mplier[0]=1, acc=acc+mcand (2·WIDTH add).
  - Then mcand<<=1, mplier>>=1, count++.
  - After exactly WIDTH iterations, A<=final acc and go to STOP.
  - No early termination; latency is fixed.
- STOP: `done`=1 and `A` holds its value.
  - Stay in STOP while `start`=1.
  - When `start`=0, go to INIT. `done` falls on that edge; `A` keeps its value.
- Input handling:
  - Q, B and R are captured only on the INIT→S1 edge.
  - Changes to them during S1 or STOP have no effect.
  - `start` is ignored in S1. Dropping it mid-computation does not abort.
- Width rule: the maximum result is (2^W−1)² + (2^W−1) = 2^2W − 2^W. It always fits in 2·WIDTH bits, so there is no overflow output.

## Timing
- Edge k samples `start`=1 in INIT.
- Edges k+1 … k+WIDTH perform the WIDTH iterations.
- `A` and `done` are valid after edge k+WIDTH:
  - WIDTH edges after the sampling edge; 32 cycles at default.
  - `busy` is high for exactly those WIDTH cycles.
- Back-to-back operation needs at least one cycle with `start`=0 to return to INIT. The minimum period is WIDTH+2 cycles.
- If `start` is held high permanently, one computation runs and the block then parks in STOP with `done`=1.
- Reset asserted mid-S1: return to INIT at once, `A`=0, `done`=0. After release, a new `start` gives a correct full-latency result.
- Reset released while `start`=1: the first rising edge after release starts a computation.
- Outputs are registered; no combinational path from inputs to `A` or `done`.

## Structure
- Shared defines header holds `WIDTH`, `STATE_WIDTH`, `INIT`=0, `S1`=1, `STOP`=2. These are common with the divider.
- Single module: FSM, counter (clog2(WIDTH)+1 bits) and shift-add datapath.
- No sub-module is warranted at this size.

## Test plan
- Basic case: Q=4, B=3, R=1, `start` pulsed. Required: A=13, `done` rises exactly 32 cycles after the sampling edge, and `busy` is high for 32 cycles.
- Extremes: Q=B=R=0xFFFFFFFF gives A=0xFFFFFFFF00000000. Q=0, R=7 gives A=7. B=0, R=0 gives A=0.
- Held start: `start` tied high from reset release. Required: exactly one computation, `done` stays 1, and A stays stable.
- Reset mid-operation: `Rst`=0 at cycle 10 of S1. Required: A=0 and `done`=0 immediately. A following Q=5, B=6, R=2 gives A=32.
- Input freeze: Q, B and R change during S1. Required: the result reflects the values captured at start.
- Round trip: 100 random dividends and nonzero divisors through `devider_main`, with its Q, B and R fed into this block. Required: A equals the original dividend every time.
